// File: rtl/md_pkg.sv
// Shared types and helpers for the multiply/divide unit: opcode encoding,
// sequencer state and opcode classification.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6,
    MFHI    = 4'd7,
    MFLO    = 4'd8
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  // Ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_md_start(md_op_t op);
    return op inside {MULT, MULTU, DIV, DIVU};
  endfunction

  function automatic logic is_md_any(md_op_t op);
    return op inside {MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO};
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath. Produces the HI/LO pair for the
// EX-stage operands; the sequencer decides when the result is committed.
module md_arith
  import md_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_safe;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic               sdiv_ovf;

  always_comb begin
    prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u   = {32'd0, a} * {32'd0, b};
    // A zero divisor is replaced so the operators never see it; div0 suppresses the commit.
    b_safe   = (b == 32'd0) ? 32'd1 : b;
    q_s      = $signed(a) / $signed(b_safe);
    r_s      = $signed(a) % $signed(b_safe);
    sdiv_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    div0     = (op inside {DIV, DIVU}) && (b == 32'd0);
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    unique case (op)
      MULT:  {res_hi, res_lo} = prod_s;
      MULTU: {res_hi, res_lo} = prod_u;
      DIV: begin
        if (sdiv_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = r_s;
          res_lo = q_s;
        end
      end
      DIVU: begin
        res_hi = a % b_safe;
        res_lo = a / b_safe;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// EX-stage multiply/divide sequencer: owns HI/LO, models op latency with a
// busy counter and requests a front-end stall for dependent D-stage MD ops.
module md_unit_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  md_op_t      md_op_e,
  input  logic [31:0] src_a_e,
  input  logic [31:0] src_b_e,
  input  logic        md_use_d,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata_e
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_t        state;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      hi_n, lo_n;
  logic [31:0]      pend_hi, pend_lo, pend_hi_n, pend_lo_n;
  logic             pend_div0, pend_div0_n;
  logic             start_e;
  logic [31:0]      ar_hi, ar_lo;
  logic             ar_div0;

  md_arith u_arith (
    .op     (md_op_e),
    .a      (src_a_e),
    .b      (src_b_e),
    .res_hi (ar_hi),
    .res_lo (ar_lo),
    .div0   (ar_div0)
  );

  // Stall contract: an MD op in D must hold while the unit is busy or a
  // start is being accepted in EX this cycle; EX never presents an MD op
  // while busy, so no accept/ready signal is needed on the EX side.
  assign state      = (cnt != '0) ? ST_BUSY : ST_IDLE;
  assign busy       = (state == ST_BUSY);
  assign start_e    = is_md_start(md_op_e);
  assign md_stall   = md_use_d & (busy | start_e);
  assign md_rdata_e = (md_op_e == MFHI) ? hi :
                      (md_op_e == MFLO) ? lo : 32'd0;

  always_comb begin
    cnt_n       = cnt;
    hi_n        = hi;
    lo_n        = lo;
    pend_hi_n   = pend_hi;
    pend_lo_n   = pend_lo;
    pend_div0_n = pend_div0;
    unique case (state)
      ST_IDLE: begin
        if (start_e) begin
          cnt_n       = (md_op_e inside {MULT, MULTU}) ? MULT_LOAD : DIV_LOAD;
          pend_hi_n   = ar_hi;
          pend_lo_n   = ar_lo;
          pend_div0_n = ar_div0;
        end else if (md_op_e == MTHI) begin
          hi_n = src_a_e;
        end else if (md_op_e == MTLO) begin
          lo_n = src_a_e;
        end
      end
      ST_BUSY: begin
        cnt_n = cnt - CNT_ONE;
        if ((cnt == CNT_ONE) && !pend_div0) begin
          hi_n = pend_hi;
          lo_n = pend_lo;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_div0 <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      hi        <= hi_n;
      lo        <= lo_n;
      pend_hi   <= pend_hi_n;
      pend_lo   <= pend_lo_n;
      pend_div0 <= pend_div0_n;
    end
  end

  // EX must never carry an MD op while an operation is in flight.
  a_no_md_op_while_busy: assert property (
    @(posedge clk) disable iff (reset) !(busy && is_md_any(md_op_e)));

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: directed scenarios plus random traffic, checked per
// cycle against a cycle-numbered reference model through an expected queue.
module tb_md_unit_ctrl;
  import md_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  md_op_t      md_op_e;
  logic [31:0] src_a_e, src_b_e;
  logic        md_use_d;
  logic        busy, md_stall;
  logic [31:0] hi, lo, md_rdata_e;

  md_unit_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk        (clk),
    .reset      (reset),
    .md_op_e    (md_op_e),
    .src_a_e    (src_a_e),
    .src_b_e    (src_b_e),
    .md_use_d   (md_use_d),
    .busy       (busy),
    .md_stall   (md_stall),
    .hi         (hi),
    .lo         (lo),
    .md_rdata_e (md_rdata_e)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [97:0] exp_q[$];   // {busy, md_stall, hi, lo, md_rdata_e}
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural HI/LO plus one pending result that
  // becomes visible after the cycle numbered m_end.
  int          cyc = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  logic        m_pend = 0, m_div0 = 0;
  int          m_end = -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic model_start(md_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  task automatic model_calc(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p;
    longint unsigned ua, ub, pu;
    m_div0 = 1'b0;
    sa = int'(a);
    sb = int'(b);
    ua = a;
    ub = b;
    case (op)
      MULT: begin
        p = sa * sb;
        {m_phi, m_plo} = p;
      end
      MULTU: begin
        pu = ua * ub;
        {m_phi, m_plo} = pu;
      end
      DIV: begin
        if (b == 0) m_div0 = 1'b1;
        else begin
          q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
          r = (sa < 0 ? -sa : sa) % (sb < 0 ? -sb : sb);
          if ((sa < 0) != (sb < 0)) q = -q;
          if (sa < 0) r = -r;
          m_plo = q[31:0];
          m_phi = r[31:0];
        end
      end
      DIVU: begin
        if (b == 0) m_div0 = 1'b1;
        else begin
          m_plo = a / b;
          m_phi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic drive(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic use_d, input logic rst);
    logic        e_busy, e_stall;
    logic [31:0] e_rd;
    @(posedge clk);
    #1;
    md_op_e  = op;
    src_a_e  = a;
    src_b_e  = b;
    md_use_d = use_d;
    reset    = rst;
    e_busy   = m_pend && (cyc <= m_end);
    e_stall  = use_d && (e_busy || model_start(op));
    e_rd     = (op == MFHI) ? m_hi : (op == MFLO) ? m_lo : 32'd0;
    exp_q.push_back({e_busy, e_stall, m_hi, m_lo, e_rd});
    if (rst) begin
      m_hi = 0; m_lo = 0; m_pend = 0; m_end = -1;
    end else if (e_busy) begin
      if (cyc == m_end) begin
        if (!m_div0) begin m_hi = m_phi; m_lo = m_plo; end
        m_pend = 0;
      end
    end else if (model_start(op)) begin
      model_calc(op, a, b);
      m_pend = 1;
      m_end  = cyc + (((op == MULT) || (op == MULTU)) ? MULT_N : DIV_N);
    end else if (op == MTHI) m_hi = a;
    else if (op == MTLO) m_lo = a;
    cyc++;
  endtask

  task automatic idle(input int n, input logic use_d);
    for (int i = 0; i < n; i++) drive(MD_NONE, 32'd0, 32'd0, use_d, 1'b0);
  endtask

  // Spec-level constants checked directly against the committed registers.
  task automatic check_hilo(input string name, input logic [31:0] e_hi, input logic [31:0] e_lo);
    #3;
    chk({name, "_hi"}, hi, e_hi);
    chk({name, "_lo"}, lo, e_lo);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic [97:0] mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("busy",       {31'd0, busy},     {31'd0, mon_e[97]});
      chk("md_stall",   {31'd0, md_stall}, {31'd0, mon_e[96]});
      chk("hi",         hi,                mon_e[95:64]);
      chk("lo",         lo,                mon_e[63:32]);
      chk("md_rdata_e", md_rdata_e,        mon_e[31:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    md_op_e  = MD_NONE;
    src_a_e  = 0;
    src_b_e  = 0;
    md_use_d = 0;
    reset    = 1;
    repeat (2) @(posedge clk);

    drive(MD_NONE, 0, 0, 0, 1);
    idle(2, 0);
    check_hilo("reset", 32'h0, 32'h0);

    drive(MULT, 32'hFFFF_FFFE, 32'd3, 0, 0);
    idle(MULT_N, 0);
    drive(MD_NONE, 0, 0, 0, 0);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    drive(MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0);
    idle(MULT_N, 0);
    drive(MD_NONE, 0, 0, 0, 0);
    check_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    drive(DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    idle(DIV_N, 0);
    drive(MD_NONE, 0, 0, 0, 0);
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    drive(DIVU, 32'd7, 32'd0, 0, 0);
    idle(DIV_N, 0);
    drive(MD_NONE, 0, 0, 0, 0);
    check_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    drive(MULT, 32'd1, 32'd1, 0, 0);
    idle(MULT_N + 1, 0);
    drive(DIV, 32'hFFFF_FFF9, 32'd2, 1, 0);
    idle(DIV_N + 1, 1);
    drive(MFLO, 0, 0, 0, 0);
    #3 chk("mflo_rdata", md_rdata_e, 32'hFFFF_FFFD);

    drive(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    idle(DIV_N, 0);
    drive(MD_NONE, 0, 0, 0, 0);
    check_hilo("div_ovf", 32'h0, 32'h8000_0000);

    drive(MTHI, 32'h1234_5678, 0, 0, 0);
    drive(MTLO, 32'h9ABC_DEF0, 0, 0, 0);
    drive(MD_NONE, 0, 0, 0, 0);
    check_hilo("mthi_mtlo", 32'h1234_5678, 32'h9ABC_DEF0);

    drive(MULT, 32'd3, 32'd4, 0, 0);
    drive(MD_NONE, 0, 0, 0, 0);
    drive(MD_NONE, 0, 0, 0, 1);
    drive(MD_NONE, 0, 0, 0, 0);
    drive(MULT, 32'd5, 32'd6, 0, 0);
    idle(MULT_N, 0);
    drive(MD_NONE, 0, 0, 0, 0);
    check_hilo("reset_abort", 32'h0, 32'd30);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 59) == 0)
        drive(MD_NONE, 0, 0, 1'($urandom_range(0, 1)), 1);
      else if (m_pend)
        drive(MD_NONE, 0, 0, 1'($urandom_range(0, 1)), 0);
      else
        drive(md_op_t'($urandom_range(0, 8)), pick_operand(), pick_operand(),
              1'($urandom_range(0, 1)), 0);
    end
    idle(DIV_N + 2, 0);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
